ras_ckpt: RTL

- Parametrised return address stack with checkpoint restore, serving the fetch predictor stage alongside btb/upct.
- Circular storage of return targets: pushes on link-type branches, pops on return-type branches.
- Exports top index/count so frontend checkpoints can snapshot them; restores both on branch mispredict or flush.
- Successor to the fixed 8-entry RAS: entry count and target width are parametrised; overflow/underflow handling and same-cycle push+pop are defined explicitly.

---
 rtl/ras_ckpt.sv | 99 +++++++++
 1 files changed

// File: rtl/ras_ckpt.sv
// Return address stack with checkpoint restore for the fetch predictor.
// Optional RAS_STATS_EN adds saturating overflow/underflow event counters.
module ras_ckpt #(
  parameter int RAS_ENTRIES      = 8,
  parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
  parameter int RAS_TARGET_WIDTH = 31,
  parameter int RAS_COUNT_WIDTH  = $clog2(RAS_ENTRIES) + 1
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] push_target,
  input  logic                        pop_valid,
  output logic [RAS_TARGET_WIDTH-1:0] ret_target,
  output logic                        ret_hit,
  output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
  output logic [RAS_COUNT_WIDTH-1:0]  ras_count,
  input  logic                        restore_valid,
  input  logic [RAS_INDEX_WIDTH-1:0]  restore_index,
  input  logic [RAS_COUNT_WIDTH-1:0]  restore_count
`ifdef RAS_STATS_EN
  ,
  output logic [15:0]                 ovf_count,
  output logic [15:0]                 udf_count
`endif
);

  localparam logic [RAS_COUNT_WIDTH-1:0] CNT_FULL = RAS_COUNT_WIDTH'(RAS_ENTRIES);
  localparam logic [RAS_COUNT_WIDTH-1:0] CNT_ONE  = RAS_COUNT_WIDTH'(1);
  localparam logic [RAS_INDEX_WIDTH-1:0] IDX_ONE  = RAS_INDEX_WIDTH'(1);

  logic [RAS_INDEX_WIDTH-1:0]  idx_q, idx_d, wr_idx;
  logic [RAS_COUNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [RAS_TARGET_WIDTH-1:0] mem_q [RAS_ENTRIES];
  logic                        wr_en;

  // Read is taken from the registered array, so same-cycle writes are not visible.
  assign ret_target = mem_q[idx_q];
  assign ret_hit    = (cnt_q != '0);
  assign ras_index  = idx_q;
  assign ras_count  = cnt_q;

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = idx_q;
    if (restore_valid) begin
      idx_d = restore_index;
      cnt_d = (restore_count > CNT_FULL) ? CNT_FULL : restore_count;
    end else if (push_valid && pop_valid) begin
      // Return-and-link replaces the top in place; an empty stack gains one entry.
      wr_en = 1'b1;
      if (cnt_q == '0) cnt_d = CNT_ONE;
    end else if (push_valid) begin
      idx_d  = idx_q + IDX_ONE;
      wr_en  = 1'b1;
      wr_idx = idx_q + IDX_ONE;
      cnt_d  = (cnt_q == CNT_FULL) ? CNT_FULL : cnt_q + CNT_ONE;
    end else if (pop_valid && (cnt_q != '0)) begin
      idx_d = idx_q - IDX_ONE;
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      idx_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_ENTRIES; i++) mem_q[i] <= '0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      if (wr_en) mem_q[wr_idx] <= push_target;
    end
  end

`ifdef RAS_STATS_EN
  logic [15:0] ovf_q, udf_q;
  logic        ovf_evt, udf_evt;

  assign ovf_evt = push_valid && !pop_valid && !restore_valid && (cnt_q == CNT_FULL);
  assign udf_evt = pop_valid && !push_valid && !restore_valid && (cnt_q == '0);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ovf_q <= '0;
      udf_q <= '0;
    end else begin
      if (ovf_evt && (ovf_q != 16'hFFFF)) ovf_q <= ovf_q + 16'd1;
      if (udf_evt && (udf_q != 16'hFFFF)) udf_q <= udf_q + 16'd1;
    end
  end

  assign ovf_count = ovf_q;
  assign udf_count = udf_q;
`endif

endmodule
